// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO receiver.
// SIPO_PARITY_EN (optional define) adds an even-parity bit after each word.
package sipo_pkg;

    typedef enum logic {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } sipo_state_t;

    localparam int SIPO_WIDTH_DEF = 4;

    // Bit-counter width for a modulo-w counter.
    function automatic int sipo_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Modulo-WIDTH bit counter with enable and terminal-count flag.
module sipo_bit_cnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = sipo_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Next count: advance on enable, wrap after the last bit.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register, cleared by the async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver, MSB first, with a one-word output
// holding register and valid/ready handshake.
// Define SIPO_PARITY_EN to expect an even-parity bit after each word.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvld_q, pvld_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shift_w;
    logic [WIDTH-1:0] word_w;
    logic             done_w;
    logic             cnt_en;
    logic             cnt_tc;

    assign shift_w = {shreg_q[WIDTH-2:0], sin};

    sipo_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (cnt_en),
        .tc_o (cnt_tc)
    );

`ifdef SIPO_PARITY_EN
    sipo_state_t state_q, state_d;
    logic        perr_q, perr_d;
    logic        perr_new;

    // FSM: collect data bits, then take one parity bit to complete the word.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_en   = 1'b0;
        done_w   = 1'b0;
        word_w   = shreg_q;
        perr_new = 1'b0;
        case (state_q)
            S_DATA: begin
                if (sin_valid) begin
                    shreg_d = shift_w;
                    cnt_en  = 1'b1;
                    if (cnt_tc) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (sin_valid) begin
                    done_w   = 1'b1;
                    perr_new = ^{shreg_q, sin};
                    state_d  = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    // FSM state and parity status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_DATA;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            perr_q  <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    // Data-only path: the word completes on the edge taking the last bit.
    always_comb begin
        shreg_d = shreg_q;
        cnt_en  = 1'b0;
        done_w  = 1'b0;
        word_w  = shift_w;
        if (sin_valid) begin
            shreg_d = shift_w;
            cnt_en  = 1'b1;
            done_w  = cnt_tc;
        end
    end

    assign parity_err = 1'b0;
`endif

    // Output holding register: load when empty or being drained, else drop
    // the new word and flag overrun.
    always_comb begin
        pout_d = pout_q;
        pvld_d = pvld_q;
        ovr_d  = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d = perr_q;
`endif
        if (done_w) begin
            if (!pvld_q || out_ready) begin
                pout_d = word_w;
                pvld_d = 1'b1;
`ifdef SIPO_PARITY_EN
                perr_d = perr_new;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (pvld_q && out_ready) begin
            pvld_d = 1'b0;
        end
    end

    // Shift register and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            pout_q  <= '0;
            pvld_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            pvld_q  <= pvld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pvld_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4); follows SIPO_PARITY_EN if defined.
module tb_sipo_rx;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       out_ready;
    logic [3:0] pout;
    logic       pout_valid;
    logic       overrun;
    logic       parity_err;

    int n_vec;
    int n_err;

    sipo_rx #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .out_ready  (out_ready),
        .pout       (pout),
        .pout_valid (pout_valid),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given serial inputs; returns 1 ns after the edge.
    task automatic tick(input logic b, input logic v);
        sin       = b;
        sin_valid = v;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
    endtask

    // All bits of a word except the one that completes it.
    task automatic send_head(input logic [3:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
            if (i == 0) break;
`endif
            tick(w[i], 1'b1);
            if (gap) tick(~w[i], 1'b0);
        end
    endtask

    // The completing bit: data bit 0, or the parity bit (par) with parity.
    task automatic send_last(input logic [3:0] w, input logic par);
`ifdef SIPO_PARITY_EN
        tick(par, 1'b1);
`else
        tick(w[0], 1'b1);
`endif
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;

        // Reset state
        #12;
        chk("rst_pout", pout, 4'h0);
        chk("rst_pvld", pout_valid, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic word 1101, valid for exactly one cycle
        send_head(4'b1101, 1'b0);
        chk("basic_pre_vld", pout_valid, 1'b0);
        send_last(4'b1101, 1'b1);
        chk("basic_pout", pout, 4'b1101);
        chk("basic_vld", pout_valid, 1'b1);
        chk("basic_perr", parity_err, 1'b0);
        tick(1'b0, 1'b0);
        chk("basic_vld_drop", pout_valid, 1'b0);
        chk("basic_pout_hold", pout, 4'b1101);

        // Gapped sin_valid: gaps are ignored
        send_head(4'b1101, 1'b1);
        chk("gap_pre_vld", pout_valid, 1'b0);
        send_last(4'b1101, 1'b1);
        chk("gap_pout", pout, 4'b1101);
        chk("gap_vld", pout_valid, 1'b1);
        tick(1'b0, 1'b0);

        // Overrun: 1101 held, 0110 dropped
        out_ready = 1'b0;
        send_head(4'b1101, 1'b0);
        send_last(4'b1101, 1'b1);
        chk("ovr_first_vld", pout_valid, 1'b1);
        send_head(4'b0110, 1'b0);
        chk("ovr_pre_ovr", overrun, 1'b0);
        chk("ovr_pre_pout", pout, 4'b1101);
        send_last(4'b0110, 1'b0);
        chk("ovr_pulse", overrun, 1'b1);
        chk("ovr_pout_kept", pout, 4'b1101);
        chk("ovr_vld_kept", pout_valid, 1'b1);
        tick(1'b0, 1'b0);
        chk("ovr_pulse_end", overrun, 1'b0);
        chk("ovr_stable", pout, 4'b1101);
        out_ready = 1'b1;
        tick(1'b0, 1'b0);
        chk("ovr_drain_vld", pout_valid, 1'b0);

        // Ready on the completion edge: load and drain together
        out_ready = 1'b0;
        send_head(4'b1101, 1'b0);
        send_last(4'b1101, 1'b1);
        send_head(4'b0110, 1'b0);
        out_ready = 1'b1;
        send_last(4'b0110, 1'b0);
        chk("b2b_vld", pout_valid, 1'b1);
        chk("b2b_pout", pout, 4'b0110);
        chk("b2b_ovr", overrun, 1'b0);
        tick(1'b0, 1'b0);
        chk("b2b_drain", pout_valid, 1'b0);

        // Reset mid-word, then a fresh word 1011
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pout", pout, 4'h0);
        chk("mid_rst_vld", pout_valid, 1'b0);
        chk("mid_rst_ovr", overrun, 1'b0);
        #2 rst = 1'b1;
        send_head(4'b1011, 1'b0);
        chk("post_rst_pre_vld", pout_valid, 1'b0);
        send_last(4'b1011, 1'b1);
        chk("post_rst_pout", pout, 4'b1011);
        chk("post_rst_vld", pout_valid, 1'b1);
        tick(1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
        // Bad parity flagged, then good parity clears it
        send_head(4'b1101, 1'b0);
        send_last(4'b1101, 1'b0);
        chk("par_bad_perr", parity_err, 1'b1);
        chk("par_bad_pout", pout, 4'b1101);
        tick(1'b0, 1'b0);
        send_head(4'b1101, 1'b0);
        send_last(4'b1101, 1'b1);
        chk("par_good_perr", parity_err, 1'b0);
        tick(1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
